// File: rtl/d_mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: datapath width, grant FSM
// state encoding and a counter-width helper.
package d_mem_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_CORE  = 2'd0,
    S_GRANT = 2'd1,
    S_EXT   = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..max; a counter that only ever holds 0 still needs one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/d_mem_arbiter_sat_counter.sv
// Saturating up-counter 0..MAX with synchronous clear. Clear wins over increment.
// Only the terminal flag is exported; the count itself stays internal.
module sat_counter
  import d_mem_arbiter_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int W = cnt_w(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  assign at_max = (cnt == MAX_V);

  // Count up, hold at MAX, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !at_max)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// Data-memory arbiter: the core owns the single-port memory by default; an
// external requester is handed the bus through a one-cycle idle handoff,
// limited to BURST_MAX beats per grant, and forced in after STARVE_LIMIT
// contended core cycles. The core is stalled while it wants memory it does
// not own.
module d_mem_arbiter
  import d_mem_arbiter_pkg::*;
#(
  parameter int WIDTH        = DATA_W,
  parameter int BURST_MAX    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_en,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             core_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [WIDTH-1:0] ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic             ext_gnt,
  output logic             ext_beat,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata
);

  arb_state_e state, next_state;
  logic wait_clr, wait_inc, wait_full;
  logic beat_clr, beat_inc, beat_last;

  // wait_cnt only has to reach STARVE_LIMIT-1: that is the cycle the grant is forced.
  sat_counter #(.MAX(STARVE_LIMIT - 1)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .clr(wait_clr), .inc(wait_inc), .at_max(wait_full)
  );

  sat_counter #(.MAX(BURST_MAX - 1)) u_beat_cnt (
    .clk(clk), .rst_n(rst_n), .clr(beat_clr), .inc(beat_inc), .at_max(beat_last)
  );

  // Next-state and counter control for the grant FSM.
  always_comb begin
    next_state = state;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    beat_clr   = 1'b0;
    beat_inc   = 1'b0;
    case (state)
      S_CORE: begin
        if (!ext_req) begin
          wait_clr = 1'b1;
        end else if (!core_en || wait_full) begin
          next_state = S_GRANT;
          wait_clr   = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_GRANT: begin
        next_state = S_EXT;
        beat_clr   = 1'b1;
        wait_clr   = 1'b1;
      end
      S_EXT: begin
        // Leaving with wait_cnt cleared guarantees the core one contended cycle.
        if (!ext_req || beat_last) begin
          next_state = S_CORE;
          beat_clr   = 1'b1;
          wait_clr   = 1'b1;
        end else begin
          beat_inc = 1'b1;
        end
      end
      default: next_state = S_CORE;
    endcase
  end

  // State and registered grant; grant is high in both S_GRANT and S_EXT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CORE;
      ext_gnt <= 1'b0;
    end else begin
      state   <= next_state;
      ext_gnt <= (next_state != S_CORE);
    end
  end

  assign ext_beat   = (state == S_EXT) && ext_req;
  assign core_stall = core_en && (state != S_CORE);

  // Memory port mux by owner; strobes are always qualified by the enable.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    case (state)
      S_CORE: begin
        mem_en = core_en;
        mem_we = core_en && core_we;
      end
      S_EXT: begin
        mem_en    = ext_req;
        mem_we    = ext_req && ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter (WIDTH=8, BURST_MAX=4, STARVE_LIMIT=3).
module tb_d_mem_arbiter;

  logic       clk, rst_n;
  logic       core_en, core_we, core_stall;
  logic [7:0] core_addr, core_wdata;
  logic       ext_req, ext_we, ext_gnt, ext_beat;
  logic [7:0] ext_addr, ext_wdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;

  int checks   = 0;
  int failures = 0;
  int beats;

  d_mem_arbiter #(.WIDTH(8), .BURST_MAX(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_en(core_en), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_beat(ext_beat),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Burst expectations for edges 1..9 after a 6-beat request (bit k-1 = edge k).
  logic [8:0] exp_g, exp_b;

  initial begin
    exp_g = 9'b111011111;
    exp_b = 9'b110011110;
    rst_n = 1'b0;
    core_en = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;

    // Reset state
    #3;
    chk("rst_gnt",   ext_gnt,    1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_mem_en", mem_en,    1'b0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Core-only write, same-cycle pass-through
    core_en = 1; core_we = 1; core_addr = 8'h06; core_wdata = 8'h5A; #1;
    chk("core_mem_en",  mem_en,     1'b1);
    chk("core_mem_we",  mem_we,     1'b1);
    chk("core_addr",    mem_addr,   8'h06);
    chk("core_wdata",   mem_wdata,  8'h5A);
    chk("core_nostall", core_stall, 1'b0);
    cyc();
    chk("core_nostall2", core_stall, 1'b0);
    chk("core_nogrant",  ext_gnt,    1'b0);

    // External request with idle core: grant at N+1, beats from N+2
    core_en = 0; core_we = 0; ext_req = 1; ext_addr = 8'h20; #1;
    chk("idle_N_gnt", ext_gnt, 1'b0);
    cyc(); #1;
    chk("idle_N1_gnt",  ext_gnt,  1'b1);
    chk("idle_N1_en",   mem_en,   1'b0);
    chk("idle_N1_beat", ext_beat, 1'b0);
    cyc(); #1;
    chk("idle_N2_beat", ext_beat, 1'b1);
    chk("idle_N2_en",   mem_en,   1'b1);
    chk("idle_N2_we",   mem_we,   1'b0);
    chk("idle_N2_addr", mem_addr, 8'h20);
    cyc(); ext_addr = 8'h21; #1;
    chk("idle_N3_beat", ext_beat, 1'b1);
    chk("idle_N3_addr", mem_addr, 8'h21);

    // ext_req drops after 2 beats; core waiting is stalled until return
    cyc(); ext_req = 0; core_en = 1; core_addr = 8'h33; #1;
    chk("drop_beat",  ext_beat,   1'b0);
    chk("drop_stall", core_stall, 1'b1);
    chk("drop_en",    mem_en,     1'b0);
    cyc(); #1;
    chk("drop_ret_stall", core_stall, 1'b0);
    chk("drop_ret_gnt",   ext_gnt,    1'b0);
    chk("drop_ret_addr",  mem_addr,   8'h33);
    chk("drop_ret_en",    mem_en,     1'b1);

    // Burst of 6 with BURST_MAX=4: 4 beats, one core cycle, 2 beats
    core_en = 0; ext_req = 1; ext_we = 1; ext_wdata = 8'h77; ext_addr = 8'h40;
    beats = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc(); #1;
      chk($sformatf("burst_gnt_e%0d", k),  ext_gnt,  exp_g[k-1]);
      chk($sformatf("burst_beat_e%0d", k), ext_beat, exp_b[k-1]);
      chk($sformatf("burst_we_e%0d", k),   mem_we,   exp_b[k-1]);
      if (ext_beat) beats++;
      if (k == 4) chk("burst_first_grant_beats", beats, 3);
    end
    chk("burst_total_beats", beats, 6);
    chk("burst_wdata", mem_wdata, 8'h77);
    ext_req = 0; ext_we = 0;
    cyc(); #1;
    chk("burst_end_gnt", ext_gnt, 1'b0);

    // Contention: core busy every cycle, forced grant at cycle 3
    core_en = 1; core_addr = 8'h10; ext_req = 1; ext_addr = 8'h50;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("cont_c%0d_gnt", c),   ext_gnt,    1'b0);
      chk($sformatf("cont_c%0d_stall", c), core_stall, 1'b0);
      chk($sformatf("cont_c%0d_addr", c),  mem_addr,   8'h10);
      cyc();
    end
    #1;
    chk("cont_c3_gnt",   ext_gnt,    1'b1);
    chk("cont_c3_stall", core_stall, 1'b1);
    chk("cont_c3_en",    mem_en,     1'b0);
    for (int b = 0; b < 4; b++) begin
      cyc(); #1;
      chk($sformatf("cont_beat%0d", b),  ext_beat,   1'b1);
      chk($sformatf("cont_stall%0d", b), core_stall, 1'b1);
      chk($sformatf("cont_addr%0d", b),  mem_addr,   8'h50);
    end
    cyc(); #1;
    chk("cont_ret_stall", core_stall, 1'b0);
    chk("cont_ret_gnt",   ext_gnt,    1'b0);
    chk("cont_ret_addr",  mem_addr,   8'h10);
    cyc(); #1;
    chk("cont_c9_gnt", ext_gnt, 1'b0);
    cyc(); #1;
    chk("cont_c10_gnt", ext_gnt, 1'b0);
    cyc(); #1;
    chk("cont_c11_gnt", ext_gnt, 1'b1);
    cyc(); #1;
    chk("cont_c12_beat", ext_beat, 1'b1);

    // Asynchronous reset mid-burst, between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",   ext_gnt,    1'b0);
    chk("arst_stall", core_stall, 1'b0);
    chk("arst_en",    mem_en,     1'b1);
    chk("arst_addr",  mem_addr,   8'h10);
    chk("arst_beat",  ext_beat,   1'b0);
    #1 rst_n = 1'b1; core_en = 0;
    cyc(); #1;
    chk("rearm_gnt", ext_gnt, 1'b1);
    chk("rearm_en",  mem_en,  1'b0);
    cyc(); #1;
    chk("rearm_beat", ext_beat, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
